// File: rtl/prim_ram_2p_stream_reader.sv
// Sweeps an address range on one port of a dual-port RAM. The read mode streams
// the words out over valid/ready. The fill mode writes a latched pattern to
// every word in the range.
module prim_ram_2p_stream_reader #(
    parameter int Width = 32,
    parameter int Depth = 128
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     start_i,
    input  logic                     mode_i,
    input  logic [$clog2(Depth)-1:0] base_addr_i,
    input  logic [$clog2(Depth):0]   len_i,
    input  logic [Width-1:0]         fill_data_i,
    input  logic                     abort_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     aborted_o,
    output logic                     ram_req_o,
    output logic                     ram_write_o,
    output logic [$clog2(Depth)-1:0] ram_addr_o,
    output logic [Width-1:0]         ram_wdata_o,
    output logic [Width-1:0]         ram_wmask_o,
    input  logic [Width-1:0]         ram_rdata_i,
    output logic                     rvalid_o,
    output logic [Width-1:0]         rdata_o,
    output logic                     rlast_o,
    input  logic                     rready_i
);
    localparam int Aw = $clog2(Depth);
    localparam logic [Aw:0]   DepthLen = (Aw+1)'(Depth);
    localparam logic [Aw:0]   OneLen   = (Aw+1)'(1);
    localparam logic [Aw-1:0] LastAddr = Aw'(Depth - 1);

    typedef enum logic [1:0] {IDLE, FILL, READ, DRAIN} state_e;

    state_e           state_reg, state_next;
    logic [Aw-1:0]    addr_reg, addr_next;
    logic [Aw:0]      remain_reg, remain_next;
    logic [Width-1:0] pattern_reg, pattern_next;
    logic             inflight_reg, inflight_next;
    logic             inflight_last_reg, inflight_last_next;
    logic             done_reg, done_next;
    logic             aborted_reg, aborted_next;

    // Two-entry FIFO that absorbs the RAM latency and downstream stalls
    logic [Width-1:0] buf_data_reg [2];
    logic [1:0]       buf_last_reg;
    logic             rd_ptr_reg, wr_ptr_reg;
    logic [1:0]       count_reg;

    logic       busy, abort_eff, pop, push, issue_rd, write_req;
    logic [2:0] occupancy;

    assign busy      = (state_reg != IDLE);
    assign abort_eff = abort_i & busy;
    assign rvalid_o  = (count_reg != 2'd0);
    assign pop       = rvalid_o & rready_i;
    // An abort drops the word returning this cycle instead of buffering it
    assign push      = inflight_reg & ~abort_eff;
    // Slots that would still be committed after this cycle's pop
    assign occupancy = {1'b0, count_reg} + {2'b00, inflight_reg} - {2'b00, pop};
    assign issue_rd  = (state_reg == READ) & ~abort_i & (occupancy < 3'd2);
    assign write_req = (state_reg == FILL) & ~abort_i;

    assign busy_o      = busy;
    assign done_o      = done_reg;
    assign aborted_o   = aborted_reg;
    assign ram_req_o   = issue_rd | write_req;
    assign ram_write_o = write_req;
    assign ram_addr_o  = ram_req_o ? addr_reg : '0;
    assign ram_wdata_o = write_req ? pattern_reg : '0;
    assign ram_wmask_o = {Width{write_req}};
    assign rdata_o     = rvalid_o ? buf_data_reg[rd_ptr_reg] : '0;
    assign rlast_o     = rvalid_o & buf_last_reg[rd_ptr_reg];

    // Next-state, address stepping and completion decode
    always_comb begin
        state_next         = state_reg;
        addr_next          = addr_reg;
        remain_next        = remain_reg;
        pattern_next       = pattern_reg;
        done_next          = 1'b0;
        aborted_next       = 1'b0;
        inflight_next      = issue_rd;
        inflight_last_next = issue_rd & (remain_reg == OneLen);
        if (issue_rd || write_req) begin
            addr_next   = (addr_reg == LastAddr) ? '0 : addr_reg + Aw'(1);
            remain_next = remain_reg - OneLen;
        end
        case (state_reg)
            IDLE: begin
                if (start_i) begin
                    if (len_i == '0) begin
                        done_next = 1'b1;
                    end else begin
                        addr_next    = base_addr_i;
                        remain_next  = (len_i > DepthLen) ? DepthLen : len_i;
                        pattern_next = fill_data_i;
                        state_next   = mode_i ? FILL : READ;
                    end
                end
            end
            FILL: begin
                if (abort_i) begin
                    state_next   = IDLE;
                    done_next    = 1'b1;
                    aborted_next = 1'b1;
                end else if (remain_reg == OneLen) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            READ: begin
                if (abort_i) begin
                    state_next   = IDLE;
                    done_next    = 1'b1;
                    aborted_next = 1'b1;
                end else if (issue_rd && remain_reg == OneLen) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (abort_i) begin
                    state_next   = IDLE;
                    done_next    = 1'b1;
                    aborted_next = 1'b1;
                end else if (pop && rlast_o) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Control state registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg         <= IDLE;
            addr_reg          <= '0;
            remain_reg        <= '0;
            pattern_reg       <= '0;
            inflight_reg      <= 1'b0;
            inflight_last_reg <= 1'b0;
            done_reg          <= 1'b0;
            aborted_reg       <= 1'b0;
        end else begin
            state_reg         <= state_next;
            addr_reg          <= addr_next;
            remain_reg        <= remain_next;
            pattern_reg       <= pattern_next;
            inflight_reg      <= inflight_next;
            inflight_last_reg <= inflight_last_next;
            done_reg          <= done_next;
            aborted_reg       <= aborted_next;
        end
    end

    // FIFO pointers, occupancy and last flags; an abort flushes everything
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_reg   <= 1'b0;
            wr_ptr_reg   <= 1'b0;
            count_reg    <= 2'd0;
            buf_last_reg <= 2'b00;
        end else if (abort_eff) begin
            rd_ptr_reg <= 1'b0;
            wr_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (push) begin
                buf_last_reg[wr_ptr_reg] <= inflight_last_reg;
                wr_ptr_reg               <= ~wr_ptr_reg;
            end
            if (pop) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            count_reg <= count_reg + 2'(push) - 2'(pop);
        end
    end

    // FIFO data storage, captured from the RAM the cycle after issue
    for (genvar gi = 0; gi < 2; gi++) begin : g_buf
        always_ff @(posedge clk_i) begin
            if (push && (wr_ptr_reg == 1'(gi))) begin
                buf_data_reg[gi] <= ram_rdata_i;
            end
        end
    end

endmodule
